// File: rtl/pcie_tlp_demux_mcast.sv
// PCIe TLP demultiplexer with multicast routing: each TLP goes to any subset of PORTS outputs.
// Define PCIE_TLP_DEMUX_MCAST_STATS_EN to build the per-port delivered and dropped TLP counters.
module pcie_tlp_demux_mcast #(
  parameter int PORTS          = 4,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int SEQ_NUM_WIDTH  = 6,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TLP_DATA_WIDTH-1:0]   in_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0]   in_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]    in_tlp_hdr,
  input  logic [SEQ_NUM_WIDTH-1:0]    in_tlp_seq,
  input  logic [2:0]                  in_tlp_bar_id,
  input  logic [7:0]                  in_tlp_func_num,
  input  logic [3:0]                  in_tlp_error,
  input  logic                        in_tlp_valid,
  input  logic                        in_tlp_sop,
  input  logic                        in_tlp_eop,
  output logic                        in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]   out_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0]   out_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]    out_tlp_hdr,
  output logic [SEQ_NUM_WIDTH-1:0]    out_tlp_seq,
  output logic [2:0]                  out_tlp_bar_id,
  output logic [7:0]                  out_tlp_func_num,
  output logic [3:0]                  out_tlp_error,
  output logic                        out_tlp_sop,
  output logic                        out_tlp_eop,
  output logic [PORTS-1:0]            out_tlp_valid,
  input  logic [PORTS-1:0]            out_tlp_ready,
  output logic [TLP_HDR_WIDTH-1:0]    match_tlp_hdr,
  output logic [2:0]                  match_tlp_bar_id,
  output logic [7:0]                  match_tlp_func_num,
  input  logic                        enable,
  input  logic                        drop,
  input  logic [PORTS-1:0]            select,
  input  logic [PORTS-1:0]            port_enable,
  output logic [PORTS*STAT_WIDTH-1:0] stat_tlp_count,
  output logic [STAT_WIDTH-1:0]       stat_drop_count
);

  logic             frame_q, frame_d;
  logic             drop_q, drop_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [PORTS-1:0] valid_q, valid_d;

  logic             xfer;
  logic [PORTS-1:0] cur_mask;
  logic             cur_drop;
  logic             stray;
  logic             drop_event;

  assign match_tlp_hdr      = in_tlp_hdr;
  assign match_tlp_bar_id   = in_tlp_bar_id;
  assign match_tlp_func_num = in_tlp_func_num;

  // A new beat may load only once every port still holding the current beat takes it now.
  assign in_tlp_ready  = enable && ((valid_q & ~out_tlp_ready) == '0);
  assign xfer          = in_tlp_valid && in_tlp_ready;
  assign out_tlp_valid = valid_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cur_mask = mask_q;
    cur_drop = drop_q;
    stray    = 1'b0;
    frame_d  = frame_q;
    mask_d   = mask_q;
    drop_d   = drop_q;
    valid_d  = valid_q & ~out_tlp_ready;
    if (in_tlp_sop) begin
      cur_mask = select & port_enable;
      cur_drop = drop || (cur_mask == '0);
    end else if (!frame_q) begin
      cur_mask = '0;
      cur_drop = 1'b1;
      stray    = 1'b1;
    end
    if (xfer) begin
      valid_d = cur_drop ? '0 : cur_mask;
      if (in_tlp_sop) begin
        mask_d  = cur_mask;
        drop_d  = cur_drop;
        frame_d = 1'b1;
      end
      if (in_tlp_eop) frame_d = 1'b0;
    end
  end

  assign drop_event = xfer && ((in_tlp_sop && cur_drop) || stray);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 1'b0;
      drop_q  <= 1'b0;
      mask_q  <= '0;
      valid_q <= '0;
    end else begin
      frame_q <= frame_d;
      drop_q  <= drop_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the shared payload is deliberately not reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (xfer) begin
      out_tlp_data     <= in_tlp_data;
      out_tlp_strb     <= in_tlp_strb;
      out_tlp_hdr      <= in_tlp_hdr;
      out_tlp_seq      <= in_tlp_seq;
      out_tlp_bar_id   <= in_tlp_bar_id;
      out_tlp_func_num <= in_tlp_func_num;
      out_tlp_error    <= in_tlp_error;
      out_tlp_sop      <= in_tlp_sop;
      out_tlp_eop      <= in_tlp_eop;
    end
  end

`ifdef PCIE_TLP_DEMUX_MCAST_STATS_EN
  logic [STAT_WIDTH-1:0] tlp_cnt_q [PORTS];
  logic [STAT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORTS; p++) tlp_cnt_q[p] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (xfer && in_tlp_eop && !cur_drop && cur_mask[p]) tlp_cnt_q[p] <= tlp_cnt_q[p] + 1'b1;
      end
      if (drop_event) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_stat
    assign stat_tlp_count[p*STAT_WIDTH +: STAT_WIDTH] = tlp_cnt_q[p];
  end
  assign stat_drop_count = drop_cnt_q;
`else
  logic unused_drop_event;
  assign unused_drop_event = drop_event;
  assign stat_tlp_count    = '0;
  assign stat_drop_count   = '0;
`endif

endmodule
